// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator; every output is registered from the next
// counter position so pixel coordinates, syncs and strobes describe the same pixel.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic        clk_div,
  input  logic        rst_n,
  input  logic        en,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic        line_tick,
  output logic        frame_tick,
  output logic [15:0] frame_count
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_DISP = 10'(H_DISPLAY);
  localparam logic [9:0] V_DISP = 10'(V_DISPLAY);
  localparam logic [9:0] HS_LO  = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_HI  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_LO  = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_HI  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  logic [9:0] nx, ny;
  logic       h_wrap, frame_hit;
  always_comb begin
    h_wrap    = pixel_x == H_LAST;
    nx        = h_wrap ? '0 : pixel_x + 10'd1;
    ny        = h_wrap ? (pixel_y == V_LAST ? '0 : pixel_y + 10'd1) : pixel_y;
    frame_hit = nx == '0 && ny == V_DISP;
  end
  // Reset parks on the last blanking pixel so the first enabled edge lands on (0,0).
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      pixel_x     <= H_LAST;
      pixel_y     <= V_LAST;
      video_on    <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_tick   <= 1'b0;
      frame_tick  <= 1'b0;
      frame_count <= '0;
    end else if (en) begin
      pixel_x     <= nx;
      pixel_y     <= ny;
      video_on    <= nx < H_DISP && ny < V_DISP;
      hsync       <= (nx >= HS_LO && nx <= HS_HI) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (ny >= VS_LO && ny <= VS_HI) ? SYNC_POL : ~SYNC_POL;
      line_tick   <= nx == '0;
      frame_tick  <= frame_hit;
      frame_count <= frame_count + 16'(frame_hit);
    end else begin
      line_tick   <= 1'b0;
      frame_tick  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: two raster generators (640x480 default and a tiny 7x6 one) checked
// each cycle against a linear-position model, plus directed sync/strobe/pause/reset checks.
module tb_vga_sync_gen;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  always #5 clk = ~clk;
  logic [9:0]  xa, ya, xb, yb;
  logic        voa, hsa, vsa, lta, fta, vob, hsb, vsb, ltb, ftb;
  logic [15:0] fca, fcb;
  vga_sync_gen u_a (
    .clk_div(clk), .rst_n(rst_n), .en(en), .pixel_x(xa), .pixel_y(ya), .video_on(voa),
    .hsync(hsa), .vsync(vsa), .line_tick(lta), .frame_tick(fta), .frame_count(fca)
  );
  vga_sync_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_POL(1'b1)
  ) u_b (
    .clk_div(clk), .rst_n(rst_n), .en(en), .pixel_x(xb), .pixel_y(yb), .video_on(vob),
    .hsync(hsb), .vsync(vsb), .line_tick(ltb), .frame_tick(ftb), .frame_count(fcb)
  );
  int n_cmp = 0, n_bad = 0;
  bit live = 1'b0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask
  // Model: k enabled edges since reset place the raster at linear index (k-1) mod total.
  int k = 0, fca_m = 0, fcb_m = 0;
  bit stepped = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0; fca_m <= 0; fcb_m <= 0; stepped <= 1'b0;
    end else if (en) begin
      k       <= k + 1;
      stepped <= 1'b1;
      fca_m   <= (fca_m + int'(k % 420000 == 480 * 800)) % 65536;
      fcb_m   <= (fcb_m + int'(k % 42 == 3 * 7)) % 65536;
    end else begin
      stepped <= 1'b0;
    end
  end
  task automatic cmp_dut(input string p, input int hd, hf, hs, hb, vd, vf, vs, vb,
                         input bit pol, input int fc, input logic [9:0] ox, oy,
                         input logic ovo, ohs, ovs, olt, oft, input logic [15:0] ofc);
    int ht, vt, pos, x, y;
    ht  = hd + hf + hs + hb;
    vt  = vd + vf + vs + vb;
    pos = (k + ht * vt - 1) % (ht * vt);
    x   = pos % ht;
    y   = pos / ht;
    check({p, ".x"}, ox, x);
    check({p, ".y"}, oy, y);
    check({p, ".video_on"}, ovo, int'(x < hd && y < vd));
    check({p, ".hsync"}, ohs, (x >= hd + hf && x < hd + hf + hs) ? pol : !pol);
    check({p, ".vsync"}, ovs, (y >= vd + vf && y < vd + vf + vs) ? pol : !pol);
    check({p, ".line_tick"}, olt, int'(stepped && x == 0));
    check({p, ".frame_tick"}, oft, int'(stepped && x == 0 && y == vd));
    check({p, ".frame_count"}, ofc, fc);
  endtask
  always @(negedge clk) begin
    if (live) begin
      cmp_dut("a", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, fca_m, xa, ya, voa, hsa, vsa, lta, fta, fca);
      cmp_dut("b", 4, 1, 1, 1, 3, 1, 1, 1, 1'b1, fcb_m, xb, yb, vob, hsb, vsb, ltb, ftb, fcb);
    end
  end
  task automatic tick();
    @(negedge clk);
    #2;
  endtask
  task automatic restart();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  initial begin
    int hs_low, hs_first, vo_fall, last_lt, vs_cnt, last_ft, n_ft, n;
    bit prev_vo;
    live = 1'b1;
    en   = 1'b1;
    repeat (3) tick();
    check("rst.x", xa, 799);
    check("rst.y", ya, 524);
    check("rst.video_on", voa, 0);
    check("rst.hsync", hsa, 1);
    check("rst.vsync", vsa, 1);
    check("rst.frame_count", fca, 0);
    check("rst.b_hsync", hsb, 0);
    rst_n = 1'b1;
    tick();
    check("first.x", xa, 0);
    check("first.y", ya, 0);
    check("first.video_on", voa, 1);
    check("first.line_tick", lta, 1);
    hs_low = 0; hs_first = -1; vo_fall = -1; last_lt = 0; prev_vo = 1'b1;
    for (int i = 1; i <= 1600; i++) begin
      tick();
      if (!hsa && i < 800) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(xa);
      end
      if (prev_vo && !voa && vo_fall < 0) vo_fall = int'(xa);
      prev_vo = voa;
      if (lta) begin
        check("line.spacing", i - last_lt, 800);
        last_lt = i;
      end
    end
    check("line.hsync_width", hs_low, 96);
    check("line.hsync_start", hs_first, 656);
    check("line.video_fall", vo_fall, 640);
    check("line.ticks_seen", last_lt, 1600);
    restart();
    vs_cnt = 0; last_ft = -1; n_ft = 0;
    for (int i = 1; i <= 90; i++) begin
      tick();
      if (vsb && i < 84) vs_cnt++;
      if (ftb) begin
        n_ft++;
        check("frame.count_at_tick", fcb, n_ft);
        if (last_ft >= 0) check("frame.spacing", i - last_ft, 42);
        last_ft = i;
      end
    end
    check("frame.vsync_width", vs_cnt, 14);
    check("frame.ticks", n_ft, 2);
    restart();
    n = 0;
    while (xa != 10'd639 && n < 2000) begin tick(); n++; end
    check("pause.reach", xa, 639);
    en = 1'b0;
    repeat (5) begin
      tick();
      check("pause.hold_x", xa, 639);
      check("pause.hold_vo", voa, 1);
      check("pause.line_tick", lta, 0);
    end
    en = 1'b1;
    tick();
    check("pause.resume_x", xa, 640);
    check("pause.resume_vo", voa, 0);
    n = 0;
    while (!ftb && n < 100) begin tick(); n++; end
    check("stretch.sync", ftb, 1);
    n = 0;
    do begin
      en = !(n >= 10 && n < 15);
      tick();
      n++;
    end while (!ftb && n < 200);
    en = 1'b1;
    check("stretch.period", n, 47);
    n = 0;
    while (xa != 10'd300 && n < 2000) begin tick(); n++; end
    check("midrst.reach", xa, 300);
    rst_n = 1'b0;
    #1;
    check("midrst.x", xa, 799);
    check("midrst.y", ya, 524);
    check("midrst.video_on", voa, 0);
    check("midrst.hsync", hsa, 1);
    check("midrst.line_tick", lta, 0);
    check("midrst.b_x", xb, 6);
    check("midrst.b_y", yb, 5);
    check("midrst.b_frame_count", fcb, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst.restart_x", xa, 0);
    check("midrst.restart_y", ya, 0);
    check("midrst.restart_tick", lta, 1);
    for (int i = 0; i < 20000; i++) begin
      en    = $urandom_range(0, 99) < 85;
      rst_n = $urandom_range(0, 1999) != 0;
      tick();
    end
    live = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
